// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
    localparam int WORD_W = 16;
    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-priority winner select with a fetch anti-starvation limit.
module mem_arb_prio import mem_arb_pkg::*; #(
    parameter int MAX_DATA_WINS = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   grant,
    output owner_t winner
);
    localparam int CW = $clog2(MAX_DATA_WINS + 1);
    logic [CW-1:0] wins_cnt;
    logic          limit;
    assign limit  = wins_cnt == CW'(MAX_DATA_WINS);
    assign winner = (d_req && !(i_req && limit)) ? OWN_D : OWN_I;
    // Only D wins that actually made I wait count towards the limit.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            wins_cnt <= '0;
        else if (grant)
            wins_cnt <= (winner == OWN_D && i_req) ? (limit ? wins_cnt : wins_cnt + 1'b1) : '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch (I) and data (D) ports onto one single-ported memory.
// Optional MEM_ARB_PERF_EN adds saturating conflict_cnt and stall_cycles counters.
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int ADDR_WIDTH    = 16,
    parameter int ACCESS_CYCLES = 1,
    parameter int MAX_DATA_WINS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_done,
    output logic [WORD_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_W-1:0]     d_wdata,
    output logic                  d_done,
    output logic [WORD_W-1:0]     d_rdata,
    output logic                  err,
    output logic                  busy,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_data_in,
    input  logic [WORD_W-1:0]     mem_data_out
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]           conflict_cnt,
    output logic [15:0]           stall_cycles
`endif
);
    localparam int CNT_W = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
    state_t                state, state_n;
    owner_t                owner, winner;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] addr_q, sel_addr;
    logic [WORD_W-1:0]     wdata_q;
    logic                  wr_q, grant, last;
    assign grant    = state == IDLE && (i_req || d_req);
    assign sel_addr = winner == OWN_D ? d_addr : i_addr;
    assign last     = state == BUSY && cnt == '0;
    assign busy     = state == BUSY;
    // Memory sees the access only on its final cycle so a write commits exactly once.
    assign mem_enable  = last;
    assign mem_wr      = last && wr_q;
    assign mem_addr    = last ? addr_q : '0;
    assign mem_data_in = last ? wdata_q : '0;
    mem_arb_prio #(.MAX_DATA_WINS(MAX_DATA_WINS)) u_prio (
        .clk(clk), .rst(rst), .i_req(i_req), .d_req(d_req), .grant(grant), .winner(winner)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    always_comb begin
        state_n = state;
        if (grant && !sel_addr[0]) state_n = BUSY;
        if (last)                  state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            owner   <= OWN_I;
            cnt     <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            if (grant) begin
                owner   <= winner;
                addr_q  <= sel_addr;
                wr_q    <= winner == OWN_D && d_wr;
                wdata_q <= d_wdata;
                cnt     <= CNT_W'(ACCESS_CYCLES - 1);
                if (sel_addr[0]) begin
                    err    <= 1'b1;
                    i_done <= winner == OWN_I;
                    d_done <= winner == OWN_D;
                    if (winner == OWN_I) i_rdata <= '0;
                    else                 d_rdata <= '0;
                end
            end else if (state == BUSY) begin
                cnt <= cnt - 1'b1;
                if (last) begin
                    i_done <= owner == OWN_I;
                    d_done <= owner == OWN_D;
                    if (!wr_q && owner == OWN_I) i_rdata <= mem_data_out;
                    if (!wr_q && owner == OWN_D) d_rdata <= mem_data_out;
                end
            end
        end
`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            conflict_cnt <= '0;
            stall_cycles <= '0;
        end else begin
            if (grant && i_req && d_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 1'b1;
            if (busy && stall_cycles != 16'hFFFF)                     stall_cycles <= stall_cycles + 1'b1;
        end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus starvation and mid-access reset sequences.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst, i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_done, d_done, err, busy, mem_enable, mem_wr;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] conflict_cnt, stall_cycles;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(16), .ACCESS_CYCLES(2), .MAX_DATA_WINS(2)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .err(err), .busy(busy),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
`ifdef MEM_ARB_PERF_EN
        , .conflict_cnt(conflict_cnt), .stall_cycles(stall_cycles)
`endif
    );

    // Memory model: combinational read, write on clock edge; word k starts as C0kk except word 8 = BEEF.
    logic [15:0] mem [0:255];
    logic        mem_ready = 1'b0;
    assign mem_data_out = mem[mem_addr[8:1]];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 256; k++) mem[k] <= (k == 8) ? 16'hBEEF : {8'hC0, 8'(k)};
            mem_ready <= 1'b1;
        end else if (mem_enable && mem_wr) begin
            mem[mem_addr[8:1]] <= mem_data_in;
        end
    end

    typedef struct packed {
        logic        is_d;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic access(input vec_t v, input int idx);
        int   lat = 0;
        int   en = 0;
        int   wn = 0;
        logic seen_i = 1'b0;
        logic seen_d = 1'b0;
        logic e = 1'b0;
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (mem_enable) en++;
            if (mem_enable && mem_wr) wn++;
            if (i_done || d_done) begin
                lat = k; seen_i = i_done; seen_d = d_done; e = err;
                break;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        chk($sformatf("v%0d latency", idx), 64'(lat), v.addr[0] ? 64'd1 : 64'd3);
        chk($sformatf("v%0d done_port", idx), {seen_i, seen_d}, v.is_d ? 2'b01 : 2'b10);
        chk($sformatf("v%0d err", idx), e, v.exp_err);
        chk($sformatf("v%0d rdata", idx), v.is_d ? d_rdata : i_rdata, v.exp_rdata);
        chk($sformatf("v%0d mem_enable_cycles", idx), 64'(en), v.addr[0] ? 64'd0 : 64'd1);
        chk($sformatf("v%0d mem_wr_cycles", idx), 64'(wn), (!v.addr[0] && v.is_d && v.wr) ? 64'd1 : 64'd0);
        if (v.is_d && v.wr && !v.addr[0])
            chk($sformatf("v%0d mem_word", idx), mem[v.addr[8:1]], v.wdata);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, " flags"}, {i_done, d_done, err, busy, mem_enable, mem_wr}, 6'b0);
        chk({name, " mem_bus"}, {mem_addr, mem_data_in}, 32'h0);
        chk({name, " rdata"}, {i_rdata, d_rdata}, 32'h0);
    endtask

    vec_t tbl [12];
    initial begin
        tbl[0]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'h0021, 16'h0000, 16'h0000, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 16'h0040, 16'h5A5A, 16'h0000, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 16'h0013, 16'h0000, 16'h0000, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h5A5A, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 16'h0041, 16'hFFFF, 16'h0000, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h5A5A, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hC000, 1'b0};

        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_outputs_zero("reset");
        @(negedge clk) rst = 1'b0;

        for (int v = 0; v < 12; v++) access(tbl[v], v);

        // Both ports held: with a limit of 2 the grant order repeats D, D, I.
        begin
            logic [5:0] order = '0;
            int got = 0;
            int both = 0;
            @(negedge clk) rst = 1'b1;
            @(negedge clk) rst = 1'b0;
            i_req = 1'b1; i_addr = 16'h0010;
            d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
            for (int k = 0; k < 60 && got < 6; k++) begin
                @(posedge clk); #1;
                if (i_done && d_done) both++;
                if (i_done || d_done) begin
                    order[5 - got] = d_done;
                    if (d_done) chk($sformatf("starve d_rdata %0d", got), d_rdata, 16'h1234);
                    else        chk($sformatf("starve i_rdata %0d", got), i_rdata, 16'hBEEF);
                    got++;
                    if (got == 6) begin i_req = 1'b0; d_req = 1'b0; end
                end
            end
            i_req = 1'b0; d_req = 1'b0;
            chk("starve grant_order", order, 6'b110110);
            chk("starve dual_done", 64'(both), 64'd0);
            repeat (3) @(posedge clk);
`ifdef MEM_ARB_PERF_EN
            #1;
            chk("perf conflict_cnt", conflict_cnt, 16'd6);
            chk("perf stall_cycles", stall_cycles, 16'd12);
`endif
        end

        // Reset while a write is one cycle from committing must abort it.
        begin
            int dones = 0;
            int ens = 0;
            @(negedge clk);
            d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0060; d_wdata = 16'h7777;
            @(posedge clk); #1;
            chk("abort busy_before", busy, 1'b1);
            rst = 1'b1;
            #1 chk_outputs_zero("abort");
            #2 d_req = 1'b0; rst = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                if (i_done || d_done) dones++;
                if (mem_enable) ens++;
            end
            chk("abort done_pulses", 64'(dones), 64'd0);
            chk("abort mem_enable", 64'(ens), 64'd0);
            chk("abort mem_word", mem[8'h30], 16'hC030);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, 16-bit, byte-addressable memory between two requesters.
- Port I is instruction fetch (read-only). Port D is data (read/write).
- Serialises accesses, since the memory forbids concurrent read and write. Models a configurable access latency and gives data accesses priority, with a fetch anti-starvation limit.
- Sits between the fetch/memory pipeline stages and the memory instance.

Parameters:
- ADDR_WIDTH, 16: byte-address width on every port.
- ACCESS_CYCLES, 1: memory busy cycles per access; must be >= 1.
- MAX_DATA_WINS, 4: consecutive D grants allowed while I waits; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request (level)
- i_addr  in  ADDR_WIDTH  fetch byte address
- i_done  out  1  one-cycle fetch completion pulse
- i_rdata  out  16  fetch read data, valid when i_done
- d_req  in  1  data request (level)
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  16  write data
- d_done  out  1  one-cycle data completion pulse
- d_rdata  out  16  data read data, valid when d_done
- err  out  1  misaligned-address flag, valid with either done pulse
- busy  out  1  access in flight (stall hint to pipeline)
- mem_enable  out  1  to memory enable
- mem_wr  out  1  to memory wr
- mem_addr  out  ADDR_WIDTH  to memory addr
- mem_data_in  out  16  to memory data_in
- mem_data_out  in  16  from memory data_out (combinational read)

Behaviour:
- Interface decision: one clock, clk; reset rst is asynchronous and active-high.
- Reset: state IDLE, counters 0. All outputs 0: done pulses, err, busy, rdata registers, mem_* outputs.
- Reset asserted mid-access aborts the access. No done pulse is issued and no memory write occurs after reset assertion.
- States:
  - IDLE: no access in flight.
  - BUSY: access in flight, with down-counter cnt.
- IDLE, no request: stay in IDLE.
- IDLE with a request:
  - Select winner: D wins unless both request and wins_cnt == MAX_DATA_WINS, in which case I wins.
  - Latch owner, addr, wr (forced 0 for I) and wdata.
  - Aligned address (addr[0] == 0): go to BUSY with cnt = ACCESS_CYCLES-1.
  - Misaligned address: no memory access; stay in IDLE. Next cycle raise the owner's done with err = 1 and rdata = 0.
- wins_cnt update on each grant:
  - D grant while i_req is high: increment, saturating at MAX_DATA_WINS.
  - I grant: clear to 0.
  - D grant while i_req is low: clear to 0.
- BUSY:
  - busy = 1.
  - cnt decrements each cycle.
  - mem_* outputs are driven from the latched values only when cnt == 0. Otherwise mem_enable = 0 and mem_wr = 0, so each write reaches memory exactly once.
- Final BUSY cycle (cnt == 0), at the clock edge:
  - Reads: owner rdata register <= mem_data_out.
  - Writes: memory commits the write and rdata is unchanged.
  - State goes to IDLE; the owner's done is pulsed, err = 0, in the following cycle.
- Latency: request sampled at edge T gives done high in cycle T+ACCESS_CYCLES+1.
- Handshake:
  - Requester holds req and request fields stable until its done cycle.
  - If req is still high in the done cycle, it is treated as a new request, so back-to-back accesses are legal.
  - Changes to request fields while BUSY are ignored (latched copy is used).
- i_done and d_done are never high in the same cycle.
- rdata registers hold their value between done pulses.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, adds two output ports, each a 16-bit counter saturating at 16'hFFFF and cleared by rst:
  - conflict_cnt: increments on every grant made while both i_req and d_req are high.
  - stall_cycles: increments every cycle busy is high.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum {IDLE, BUSY};
  - owner enum {OWN_I, OWN_D};
  - constant WORD_W = 16.
- One natural sub-module, mem_arb_prio: combinational winner select plus the wins_cnt register and its saturation logic.
- Datapath latches and the FSM stay in the top level.

Test Plan:
- Single fetch: ACCESS_CYCLES=1, memory word at byte 0x0010 = 16'hBEEF; i_req=1, i_addr=16'h0010 -> i_done one cycle high in cycle T+2, i_rdata=16'hBEEF, err=0, exactly one mem_enable cycle with mem_wr=0.
- Write then read: d_wr=1, d_addr=16'h0020, d_wdata=16'h1234, then read from 16'h0020 -> d_rdata=16'h1234; mem_enable&mem_wr high for exactly one cycle.
- Starvation guard: MAX_DATA_WINS=2, i_req and d_req both held high -> grant order D, D, I, D, D, I; i_rdata and d_rdata match the addressed words.
- Misaligned: d_addr=16'h0021 -> next cycle d_done=1, err=1, d_rdata=0, mem_enable never asserted.
- Latency/reset: ACCESS_CYCLES=3, write pending, rst pulsed at cnt==1 -> no done pulse, target word unchanged, all outputs 0 immediately (asynchronous).
- PERF (MEM_ARB_PERF_EN): 5 contended grants at ACCESS_CYCLES=2 -> conflict_cnt=5, stall_cycles=10.
